// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: select codes, FSM encoding, operand width.
// No logic; types and localparams only.
// No flow control.
package alu_arbiter_pkg;

    localparam int OP_W = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted req at or above ptr, wrapping at N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_gnt
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    logic [IDX_W:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!any_gnt && req[cand[IDX_W-1:0]]) begin
                any_gnt                 = 1'b1;
                gnt[cand[IDX_W-1:0]]    = 1'b1;
                gnt_idx                 = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between NUM_REQ requesters with round-robin grant.
// Latency: grant cycle -> EXEC -> rsp_valid two clocks after the grant cycle begins.
// Backpressure: response held until rsp_ready; no new grant until the response is taken.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0]    req_sel,
    output logic [31:0]             alu_a,
    output logic [31:0]             alu_b,
    output logic [2:0]              alu_sel,
    input  logic [31:0]             alu_out,
    input  logic                    alu_zero,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    rsp_zero,
    output logic                    busy
);

    localparam logic [ID_W:0] NUM_W = (ID_W+1)'(NUM_REQ);

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] pend_id;
    logic [ID_W-1:0] gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic            any_gnt;
    logic            grant_fire;
    logic [ID_W:0]   ptr_inc;
    logic [ID_W-1:0] ptr_nxt;

    logic [OP_W-1:0] a_arr   [NUM_REQ];
    logic [OP_W-1:0] b_arr   [NUM_REQ];
    logic [2:0]      sel_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]   = req_a[OP_W*i +: OP_W];
        assign b_arr[i]   = req_b[OP_W*i +: OP_W];
        assign sel_arr[i] = req_sel[3*i +: 3];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    assign grant_fire = (state == IDLE) && any_gnt;
    // Gated by rst_n so no requester sees an accept while reset is held.
    assign req_ready  = ((state == IDLE) && rst_n) ? gnt : '0;
    assign busy       = (state != IDLE);

    assign ptr_inc = {1'b0, gnt_idx} + (ID_W+1)'(1);
    assign ptr_nxt = (ptr_inc == NUM_W) ? '0 : ptr_inc[ID_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_gnt) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            pend_id    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            if (grant_fire) begin
                alu_a   <= a_arr[gnt_idx];
                alu_b   <= b_arr[gnt_idx];
                alu_sel <= sel_arr[gnt_idx];
                pend_id <= gnt_idx;
                rr_ptr  <= ptr_nxt;
            end
            if (state == EXEC) begin
                rsp_result <= alu_out;
                rsp_zero   <= alu_zero;
                rsp_id     <= pend_id;
                rsp_valid  <= 1'b1;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
